// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: key edge detection, IDLE/RUN/LAP/PAUSE sequencing,
// prescaled hundredths tick and a cs/sec/min modulo cascade with lap capture.
module stopwatch_ctrl #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [6:0] cs,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       running,
  output logic       lap_frozen,
  output logic       ovf
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_PAUSE} state_t;

  state_t          state, state_nxt;
  logic            start_q, lap_q, clear_q;
  logic            ev_start, ev_lap, ev_clear;
  logic            counting, tick;
  logic [PW-1:0]   presc, presc_nxt;
  logic [6:0]      cnt_cs, cs_nxt, lap_cs, lap_cs_nxt;
  logic [5:0]      cnt_sec, sec_nxt, lap_sec, lap_sec_nxt;
  logic [5:0]      cnt_min, min_nxt, lap_min, lap_min_nxt;
  logic            ovf_nxt;

  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] vmax);
    return (v == vmax) ? 7'd0 : v + 7'd1;
  endfunction

  assign ev_start = btn_start & ~start_q;
  assign ev_lap   = btn_lap   & ~lap_q;
  assign ev_clear = btn_clear & ~clear_q;

  assign counting = (state == S_RUN) || (state == S_LAP);
  assign tick     = counting && (presc == PMAX);

  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc;
    cs_nxt      = cnt_cs;
    sec_nxt     = cnt_sec;
    min_nxt     = cnt_min;
    lap_cs_nxt  = lap_cs;
    lap_sec_nxt = lap_sec;
    lap_min_nxt = lap_min;
    ovf_nxt     = ovf;

    if (counting) begin
      presc_nxt = tick ? '0 : presc + PW'(1);
    end
    if (tick) begin
      cs_nxt = wrap_inc(cnt_cs, 7'd99);
      if (cnt_cs == 7'd99) begin
        sec_nxt = 6'(wrap_inc({1'b0, cnt_sec}, 7'd59));
        if (cnt_sec == 6'd59) begin
          min_nxt = 6'(wrap_inc({1'b0, cnt_min}, 7'd59));
          if (cnt_min == 6'd59) ovf_nxt = 1'b1;
        end
      end
    end

    // Only the highest-priority event that means something in this state acts.
    unique case (state)
      S_IDLE: begin
        if (ev_start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (ev_start) begin
          state_nxt = S_PAUSE;
        end else if (ev_lap) begin
          state_nxt   = S_LAP;
          lap_cs_nxt  = cnt_cs;
          lap_sec_nxt = cnt_sec;
          lap_min_nxt = cnt_min;
        end
      end
      S_LAP: begin
        if (ev_start)    state_nxt = S_PAUSE;
        else if (ev_lap) state_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (ev_clear) begin
          state_nxt = S_IDLE;
          presc_nxt = '0;
          cs_nxt    = '0;
          sec_nxt   = '0;
          min_nxt   = '0;
          ovf_nxt   = 1'b0;
        end else if (ev_start) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      lap_q      <= 1'b0;
      clear_q    <= 1'b0;
      presc      <= '0;
      cnt_cs     <= '0;
      cnt_sec    <= '0;
      cnt_min    <= '0;
      lap_cs     <= '0;
      lap_sec    <= '0;
      lap_min    <= '0;
      ovf        <= 1'b0;
      running    <= 1'b0;
      lap_frozen <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_q    <= btn_start;
      lap_q      <= btn_lap;
      clear_q    <= btn_clear;
      presc      <= presc_nxt;
      cnt_cs     <= cs_nxt;
      cnt_sec    <= sec_nxt;
      cnt_min    <= min_nxt;
      lap_cs     <= lap_cs_nxt;
      lap_sec    <= lap_sec_nxt;
      lap_min    <= lap_min_nxt;
      ovf        <= ovf_nxt;
      running    <= (state_nxt == S_RUN) || (state_nxt == S_LAP);
      lap_frozen <= (state_nxt == S_LAP);
    end
  end

  // lap_frozen is the registered copy of "state is LAP", so it selects the display.
  assign cs  = lap_frozen ? lap_cs  : cnt_cs;
  assign sec = lap_frozen ? lap_sec : cnt_sec;
  assign min = lap_frozen ? lap_min : cnt_min;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch controller that sequences a cascade of modulo-k counters (hundredths mod 100, seconds mod 60, minutes mod 60) from a prescaled tick. It sits between debounced board keys and the seven-segment/LED display logic. A four-state FSM decides when the counter chain is enabled, frozen for a lap readout, paused or cleared.

## Interface
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 100, hundredths tick rate; DIV = CLK_HZ/TICK_HZ, must be ≥ 2 (elaboration error otherwise).

Ports:
- clk  in  1  system clock, all state on posedge.
- aclr  in  1  asynchronous reset, active-low.
- btn_start  in  1  start/stop key, active-high level, synchronous and debounced upstream.
- btn_lap  in  1  lap key, same rules.
- btn_clear  in  1  clear key, same rules.
- cs  out  7  hundredths of a second displayed, 0..99.
- sec  out  6  seconds displayed, 0..59.
- min  out  6  minutes displayed, 0..59.
- running  out  1  high in RUN or LAP.
- lap_frozen  out  1  high in LAP; display shows captured value.
- ovf  out  1  sticky, set when the count wraps 59:59.99 → 00:00.00.

## Operation
- Each key passes through its own registered previous-value flop. The event is key & ~key_q, a rising edge only. Held keys produce one event.
- Same-cycle event priority: clear > start > lap. Only the highest-priority valid event acts.
- States and transitions:
  - IDLE: counters zero. start → RUN. lap and clear have no effect.
  - RUN: start → PAUSE. lap → LAP, capturing live cs/sec/min into the lap register. clear ignored.
  - LAP: counting continues. lap → RUN, display live again. start → PAUSE, display live, lap register discarded. clear ignored.
  - PAUSE: start → RUN. clear → IDLE, zeroing counters, prescaler and ovf. lap ignored.
- Prescaler: 0..DIV-1 counter. It increments only when the state before the edge is RUN or LAP and holds in PAUSE, so a resume continues mid-tick. tick = (prescaler == DIV-1) & state in {RUN, LAP}.
- Cascade on tick:
  - cs increments, wrapping 99 → 0.
  - sec increments when cs == 99, wrapping 59 → 0.
  - min increments when cs == 99 and sec == 59, wrapping 59 → 0.
  - All three at max on tick: all go to 0 and ovf ← 1. ovf stays set until clear or reset.
- Display mux: cs/sec/min = lap register when in LAP, otherwise the live counters.

## Timing
- Reset (aclr low, asynchronous): state IDLE; all counters, prescaler and lap register 0; cs = sec = min = 0; running = 0, lap_frozen = 0, ovf = 0; key_q flops 0.
- Reset released with a key already high counts as a rising edge on the first clock.
- Key high before edge k: state changes at edge k. running/lap_frozen are registered and reflect the new state after edge k.
- RUN entered at edge k from IDLE: prescaler reaches DIV-1 after edge k+DIV-1, and cs becomes 1 at edge k+DIV. The first tick takes exactly DIV cycles.
- Lap capture at edge k loads the pre-edge live values. An increment at the same edge goes to the live counters only.
- Freezing: with lap_frozen high, outputs change only on leaving LAP. The live value appears after that edge.
- aclr mid-operation overrides everything immediately, with no partial state retained.
- All outputs are registered or muxed from registers; there are no combinational paths from keys to outputs.

## Test plan
- Bench parameters: CLK_HZ = 1000, TICK_HZ = 100, so DIV = 10.
- Basic run: reset, pulse start → running = 1 next edge; cs = 1 exactly 10 cycles after RUN entry; cs = 0 and sec = 1 after 1000 cycles.
- Pause/resume: pause at prescaler = 4, idle 500 cycles → outputs and prescaler unchanged. Start → next cs increment exactly 6 cycles after RUN re-entry.
- Lap: press lap at cs = 37 → outputs hold 00:00.37, lap_frozen = 1, live count continues. Lap again → live value (e.g. 00:00.52) shown next edge. Lap then start from LAP → PAUSE with live display.
- Wrap: force or run to 59:59.99, one tick → 00:00.00 and ovf = 1. Clear in PAUSE → IDLE, ovf = 0, all zero.
- Priority/ignore: start and clear rising together in PAUSE → IDLE. Clear in RUN → ignored, count continues. Held start for 50 cycles → single transition.
- Async reset: aclr low mid-RUN at 01:23.45, between clock edges → outputs 0, running = 0 immediately. After release, start → normal count from 0.
